// File: rtl/fa_pipe_acc.sv
// Pipelined add/subtract/accumulate unit with optional signed saturation,
// carry/overflow flags and valid/ready handshakes on both sides.
module fa_pipe_acc #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ACC  = 2'd2,
        OP_LOAD = 2'd3
    } op_t;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc;
    logic [LAT-1:0]   vld_q;
    logic [WIDTH-1:0] res_q   [LAT];
    logic [LAT-1:0]   carry_q;
    logic [LAT-1:0]   ovf_q;

    logic             stall;
    logic             accept;
    op_t              op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             c_n;
    logic             o_n;

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign out_valid = vld_q[LAT-1];
    assign out       = res_q[LAT-1];
    assign carry     = carry_q[LAT-1];
    assign ovf       = ovf_q[LAT-1];

    assign op = op_t'(mode);

    always_comb begin
        opa  = (op == OP_ACC) ? acc : a;
        opb  = (op == OP_ACC) ? a : b;
        sum  = {1'b0, opa} + {1'b0, opb};
        diff = {1'b0, a} - {1'b0, b};
        raw  = sum[WIDTH-1:0];
        c_n  = 1'b0;
        o_n  = 1'b0;
        unique case (op)
            OP_ADD, OP_ACC: begin
                raw = sum[WIDTH-1:0];
                c_n = sum[WIDTH];
                o_n = (opa[WIDTH-1] == opb[WIDTH-1]) && (raw[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                // bit WIDTH of the zero-extended difference is already the borrow
                raw = diff[WIDTH-1:0];
                c_n = diff[WIDTH];
                o_n = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LOAD: begin
                raw = a;
            end
            default: ;
        endcase
        // a wrapped negative result means positive overflow and vice versa
        if (sat && o_n)
            res = raw[WIDTH-1] ? MAX_POS : MIN_NEG;
        else
            res = raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            for (int unsigned i = 0; i < LAT; i++)
                res_q[i] <= '0;
        end else begin
            if (accept && mode[1])
                acc <= res;
            if (!stall) begin
                vld_q[0] <= accept;
                if (accept) begin
                    res_q[0]   <= res;
                    carry_q[0] <= c_n;
                    ovf_q[0]   <= o_n;
                end
                for (int unsigned i = 1; i < LAT; i++) begin
                    vld_q[i]   <= vld_q[i-1];
                    res_q[i]   <= res_q[i-1];
                    carry_q[i] <= carry_q[i-1];
                    ovf_q[i]   <= ovf_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_fa_pipe_acc.sv
// Self-checking bench for fa_pipe_acc: directed scenarios plus random traffic
// scored against an integer-arithmetic reference model.
module tb_fa_pipe_acc;

    localparam int WIDTH = 16;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovf;

    fa_pipe_acc #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .sat(sat), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .carry(carry), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o;
        logic        c;
        logic        v;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_acc;
    int          checks;
    int          errors;
    logic        hold_pend;
    logic [15:0] hold_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Signed/unsigned integer view of each operation, clamped or truncated afterwards.
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  input logic [1:0] md, input logic s,
                                  input logic [15:0] ac,
                                  output logic [15:0] r, output logic c, output logic o);
        int sx, sy, sr, ux, uy;
        if (md == 2'd3) begin
            r = x; c = 1'b0; o = 1'b0;
            return;
        end
        if (md == 2'd2) begin
            sx = int'($signed(ac)); ux = int'(ac);
            sy = int'($signed(x));  uy = int'(x);
        end else begin
            sx = int'($signed(x)); ux = int'(x);
            sy = int'($signed(y)); uy = int'(y);
        end
        if (md == 2'd1) begin
            sr = sx - sy;
            c  = (ux < uy);
        end else begin
            sr = sx + sy;
            c  = (ux + uy) > 65535;
        end
        o = (sr > 32767) || (sr < -32768);
        if (s && o)
            r = (sr > 0) ? 16'h7FFF : 16'h8000;
        else
            r = 16'(sr);
    endfunction

    // One clock: drive, check outputs, score handshakes, advance to the next negedge.
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [1:0] im, input logic is, input logic ordy,
                        output logic took);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        mode      = im;
        sat       = is;
        out_ready = ordy;
        #1;
        if (hold_pend) begin
            chk("hold_valid", {31'b0, out_valid}, 1);
            chk("hold_data", {16'b0, out}, {16'b0, hold_out});
        end
        chk("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !ordy)});
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_out", {31'b0, out_valid}, 0);
            end else begin
                e = q.pop_front();
                chk("out", {16'b0, out}, {16'b0, e.o});
                chk("carry", {31'b0, carry}, {31'b0, e.c});
                chk("ovf", {31'b0, ovf}, {31'b0, e.v});
            end
        end
        hold_pend = out_valid && !ordy;
        hold_out  = out;
        took = iv && in_ready;
        if (took) begin
            model(ia, ib, im, is, m_acc, e.o, e.c, e.v);
            q.push_back(e);
            if (im[1])
                m_acc = e.o;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] ia, input logic [15:0] ib,
                        input logic [1:0] im, input logic is);
        logic took;
        took = 1'b0;
        for (int k = 0; k < 8 && !took; k++)
            step(1'b1, ia, ib, im, is, 1'b1, took);
        if (!took)
            chk("send_timeout", {31'b0, took}, 1);
    endtask

    task automatic drain();
        logic took;
        for (int k = 0; k < 20 && q.size() != 0; k++)
            step(1'b0, 'x, 'x, 'x, 'x, 1'b1, took);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic took;
        checks    = 0;
        errors    = 0;
        hold_pend = 1'b0;
        m_acc     = '0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; mode = '0; sat = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_out", {16'b0, out}, 0);
        chk("rst_flags", {30'b0, carry, ovf}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rdy_after_rst", {31'b0, in_ready}, 1);

        // Latency: 0x1234 + 0x0FFF
        step(1'b1, 16'h1234, 16'h0FFF, 2'd0, 1'b0, 1'b1, took);
        for (int k = 1; k < LAT; k++) begin
            in_valid = 1'b0;
            #1 chk("lat_early", {31'b0, out_valid}, 0);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("lat_on", {31'b0, out_valid}, 1);
        chk("tp1_out", {16'b0, out}, 32'h2233);
        drain();

        // Carry, overflow and saturation corners
        send(16'hFFFF, 16'h0001, 2'd0, 1'b0);
        send(16'h7FFF, 16'h0001, 2'd0, 1'b1);
        send(16'h8000, 16'h0001, 2'd1, 1'b1);
        send(16'h8000, 16'h0001, 2'd1, 1'b0);
        send(16'h0000, 16'h0001, 2'd1, 1'b0);
        send(16'h8000, 16'h8000, 2'd0, 1'b1);
        drain();

        // Load then chained accumulation
        send(16'h0010, 'x, 2'd3, 1'b0);
        send(16'h0005, 'x, 2'd2, 1'b0);
        send(16'h0003, 'x, 2'd2, 1'b0);
        send(16'hFFFF, 'x, 2'd2, 1'b0);
        drain();
        chk("acc_model", {16'b0, m_acc}, 32'h0017);

        // Backpressure mid-stream
        for (int i = 0; i < 4; i++)
            send(16'($urandom), 16'($urandom), 2'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 2'd0, 1'b0, 1'b0, took);
        for (int i = 0; i < 4; i++)
            send(16'($urandom), 16'($urandom), 2'd0, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) < 7), took);
        drain();

        // Reset with beats in flight
        send(16'h0018, 'x, 2'd3, 1'b0);
        send(16'h0100, 16'h0001, 2'd0, 1'b0);
        send(16'h0200, 16'h0002, 2'd0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_out", {16'b0, out}, 0);
        q.delete();
        m_acc     = '0;
        hold_pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < LAT + 1; k++)
            step(1'b0, 'x, 'x, 'x, 'x, 1'b1, took);
        send(16'h0001, 'x, 2'd2, 1'b0);
        drain();
        chk("post_rst_acc", {16'b0, m_acc}, 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
